// File: rtl/stream_framer.sv
// Pixel stream to AXI4-Stream video framer: tags SOF (tuser) and EOL (tlast) on a 1-deep output register.
// Optional status outputs (frame_count, underrun) are enabled by defining STREAM_FRAMER_STATUS_EN.
module stream_framer #(
    parameter int WIDTH = 32,
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIM_W-1:0] frame_width,
    input  logic [DIM_W-1:0] frame_height,
    input  logic [WIDTH-1:0] datain,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
`ifdef STREAM_FRAMER_STATUS_EN
    ,
    output logic [15:0]      frame_count,
    output logic             underrun
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [DIM_W-1:0] w_m1, h_m1, col, row;
    logic             sof;
    logic             dims_ok, accept, end_col, end_px, start;

    assign dims_ok   = (|frame_width) & (|frame_height);
    assign dst_rdy_o = (state == RUN) & (~m_axis_tvalid | m_axis_tready);
    assign accept    = src_rdy_i & dst_rdy_o;
    assign end_col   = (col == w_m1);
    assign end_px    = accept & end_col & (row == h_m1);
    // A new frame starts from IDLE, or back-to-back on the last pixel of the current one.
    assign start     = enable & dims_ok & ((state == IDLE) | end_px);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)           state_nxt = RUN;
            RUN:  if (end_px && !start) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Frame position counters and latched dimensions (stored minus one)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_m1 <= '0;
            h_m1 <= '0;
            col  <= '0;
            row  <= '0;
            sof  <= 1'b1;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            sof <= 1'b1;
        end else if (start) begin
            w_m1 <= frame_width - DIM_W'(1);
            h_m1 <= frame_height - DIM_W'(1);
            col  <= '0;
            row  <= '0;
            sof  <= 1'b1;
        end else if (accept) begin
            sof <= 1'b0;
            if (end_col) begin
                col <= '0;
                row <= (row == h_m1) ? '0 : row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

    // Output register: loads on accept, holds under backpressure, empties on handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (clear) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= datain;
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= sof;
            m_axis_tlast  <= end_col;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

`ifdef STREAM_FRAMER_STATUS_EN
    logic beat_eof;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_eof    <= 1'b0;
            frame_count <= '0;
            underrun    <= 1'b0;
        end else if (clear) begin
            beat_eof    <= 1'b0;
            frame_count <= '0;
            underrun    <= 1'b0;
        end else begin
            if (accept) beat_eof <= end_col & (row == h_m1);
            // A frame counts once its final pixel leaves on the output side.
            if (m_axis_tvalid && m_axis_tready && beat_eof) frame_count <= frame_count + 16'd1;
            if ((state == RUN) && dst_rdy_o && !src_rdy_i && !sof) underrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer: scoreboard of expected beats, immediate-assertion checks.
module tb_stream_framer;

    localparam int WIDTH = 32;
    localparam int DIM_W = 12;

    logic             clk;
    logic             reset_n;
    logic             clear;
    logic             enable;
    logic [DIM_W-1:0] frame_width;
    logic [DIM_W-1:0] frame_height;
    logic [WIDTH-1:0] datain;
    logic             src_rdy_i;
    logic             dst_rdy_o;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tuser;
    logic             m_axis_tlast;
    logic             m_axis_tready;
`ifdef STREAM_FRAMER_STATUS_EN
    logic [15:0]      frame_count;
    logic             underrun;
`endif

    stream_framer #(.WIDTH(WIDTH), .DIM_W(DIM_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .enable       (enable),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .datain       (datain),
        .src_rdy_i    (src_rdy_i),
        .dst_rdy_o    (dst_rdy_o),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
`ifdef STREAM_FRAMER_STATUS_EN
        ,
        .frame_count  (frame_count),
        .underrun     (underrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic tog = 1'b0;
    logic [WIDTH+1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: land 1 time unit after the rising edge, optionally toggle tready, settle.
    task automatic step();
        @(posedge clk);
        #1;
        if (tog) m_axis_tready = ~m_axis_tready;
        #1;
    endtask

    // Send n pixels base..base+n-1 as the start of a frame of width w; expected tags from index.
    task automatic send_pixels(input int w, input int base, input int n, input logic keep_en);
        for (int i = 0; i < n; i++) begin
            int waited;
            src_rdy_i = 1'b1;
            datain    = WIDTH'(base + i);
            waited    = 0;
            while (!dst_rdy_o && waited < 100) begin
                step();
                waited++;
            end
            if (!dst_rdy_o) begin
                check("accept_timeout", 64'(dst_rdy_o), 64'd1);
                src_rdy_i = 1'b0;
                return;
            end
            sb_q.push_back({WIDTH'(base + i), (i == 0), ((i % w) == w - 1)});
            step();
            if (i == 0) begin
                enable = keep_en;
                check("first_beat_valid", 64'(m_axis_tvalid), 64'd1);
                check("first_beat_data", 64'(m_axis_tdata), 64'(base));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) step();
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Output monitor: pop/compare on handshake, and require stalled beats to stay put.
    logic             stall_prev = 1'b0;
    logic [WIDTH+2:0] held       = '0;
    always @(negedge clk) begin
        logic [WIDTH+1:0] exp;
        if (stall_prev)
            check("stall_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(held));
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
            end else begin
                exp = sb_q.pop_front();
                check("beat", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(exp));
            end
        end
        stall_prev <= m_axis_tvalid & ~m_axis_tready;
        held       <= {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end

    initial begin
        reset_n       = 1'b1;
        clear         = 1'b0;
        enable        = 1'b0;
        frame_width   = '0;
        frame_height  = '0;
        datain        = '0;
        src_rdy_i     = 1'b0;
        m_axis_tready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset_state", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, dst_rdy_o}), 64'd0);
        check("reset_tdata", 64'(m_axis_tdata), 64'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        check("idle_dst_rdy", 64'(dst_rdy_o), 64'd0);

        // 4x2 frame, tready held high
        frame_width = 4; frame_height = 2; enable = 1'b1;
        send_pixels(4, 0, 8, 1'b0);
        src_rdy_i = 1'b0;
        drain();
        check("idle_after_frame", 64'(dst_rdy_o), 64'd0);

        // Same frame with tready toggling every cycle; dims changed mid-frame must be ignored
        tog = 1'b1; enable = 1'b1;
        step();
        frame_width = 2; frame_height = 5;
        send_pixels(4, 0, 8, 1'b0);
        src_rdy_i = 1'b0;
        drain();
        tog = 1'b0; m_axis_tready = 1'b1;
        step();

        // Zero width never starts a frame
        frame_width = 0; frame_height = 2; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("zero_dim_dst_rdy", 64'(dst_rdy_o), 64'd0);
        end
        enable = 1'b0;

        // 3x3 frame aborted by clear after 4 accepts, then a fresh 3x3 frame
        frame_width = 3; frame_height = 3; enable = 1'b1;
        send_pixels(3, 100, 4, 1'b1);
        src_rdy_i = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("clear_dst_rdy", 64'(dst_rdy_o), 64'd0);
        check("clear_sb_empty", 64'(sb_q.size()), 64'd0);
        send_pixels(3, 200, 9, 1'b0);
        src_rdy_i = 1'b0;
        drain();

        // Asynchronous reset mid-line: outputs clear with no clock edge
        frame_width = 4; frame_height = 2; enable = 1'b1;
        send_pixels(4, 300, 3, 1'b1);
        src_rdy_i = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_out", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, dst_rdy_o}), 64'd0);
        check("async_reset_tdata", 64'(m_axis_tdata), 64'd0);
        check("pending_discarded", 64'(sb_q.size()), 64'd1);
        sb_q.delete();
        enable = 1'b0;
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_reset_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Back-to-back 2x1 frames with enable held across the boundary
        clear = 1'b1;
        step();
        clear = 1'b0;
        frame_width = 2; frame_height = 1; enable = 1'b1;
        send_pixels(2, 400, 2, 1'b1);
        send_pixels(2, 402, 2, 1'b0);
        src_rdy_i = 1'b0;
        drain();
        step();
`ifdef STREAM_FRAMER_STATUS_EN
        check("frame_count", 64'(frame_count), 64'd2);
        check("underrun", 64'(underrun), 64'd0);
`endif
        check("final_idle", 64'(dst_rdy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
